// File: rtl/collect_adc_data.sv
`default_nettype none
// ============================================================================
//  Module      : collect_adc_data
//  Description : Reads one multi-channel frame from a serial ADC after each
//                data-ready fall, publishes it on mat and pulses CASCOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module collect_adc_data #(
    parameter int CHANNELS  = 4,
    parameter int WORD_BITS = 32,
    parameter int SCLK_DIV  = 4,
    parameter int PULSE_LEN = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 drdy_n,
    input  logic                                 dout,
    output logic                                 sclk,
    output logic                                 cs_n,
    output logic [CHANNELS-1:0][WORD_BITS-1:0]   mat,
    output logic                                 CASCOUT,
    output logic                                 busy,
    output logic                                 overrun
);

    localparam int c_NBITS = CHANNELS * WORD_BITS;
    localparam int c_BIT_W = $clog2(c_NBITS + 1);
    localparam int c_DIV_W = $clog2(SCLK_DIV + 1);
    localparam int c_PUL_W = $clog2(PULSE_LEN + 1);

    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_NBITS - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCLK_DIV - 1);
    localparam logic [c_PUL_W-1:0] c_PUL_LAST = c_PUL_W'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                            r_state;
    state_t                            w_next;
    logic                              r_sync1;
    logic                              r_sync2;
    logic                              r_sync3;
    logic                              w_fall;
    logic [c_DIV_W-1:0]                r_div;
    logic [c_BIT_W-1:0]                r_bit;
    logic [c_PUL_W-1:0]                r_pulse;
    logic                              r_sclk;
    logic [c_NBITS-1:0]                r_shift;
    logic [CHANNELS-1:0][WORD_BITS-1:0] w_frame;
    logic                              w_div_last;
    logic                              w_bit_last;
    logic                              w_shift_end;
    logic                              w_pulse_last;

    assign w_fall       = r_sync3 & ~r_sync2;
    assign w_div_last   = (r_div == c_DIV_LAST);
    assign w_bit_last   = (r_bit == c_BIT_LAST);
    assign w_shift_end  = (r_state == SHIFT) && r_sclk && w_div_last && w_bit_last;
    assign w_pulse_last = (r_pulse == c_PUL_LAST);
    assign sclk         = r_sclk;

    // First received bit sits at the top of r_shift; it belongs to channel 0's MSB.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign w_frame[gi] = r_shift[(CHANNELS-1-gi)*WORD_BITS +: WORD_BITS];
        end
    endgenerate

    // Two-flop synchronizer for drdy_n plus one delay stage for fall detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= drdy_n;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next  = r_state;
        cs_n    = 1'b1;
        busy    = 1'b1;
        CASCOUT = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_fall) w_next = START;
            end
            START: begin
                cs_n = 1'b0;
                if (w_div_last) w_next = SHIFT;
            end
            SHIFT: begin
                cs_n = 1'b0;
                if (w_shift_end) w_next = DONE;
            end
            DONE: begin
                CASCOUT = 1'b1;
                if (w_pulse_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Divider, bit counter, serial clock, shift register, frame output, overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_pulse <= '0;
            r_sclk  <= 1'b0;
            r_shift <= '0;
            mat     <= '0;
            overrun <= 1'b0;
        end else begin
            // A fall while busy (including the final DONE cycle) is a missed frame.
            if (w_fall && (r_state != IDLE)) overrun <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_div  <= '0;
                        r_bit  <= '0;
                        r_sclk <= 1'b0;
                    end
                end
                START: begin
                    r_div <= w_div_last ? '0 : r_div + c_DIV_W'(1);
                end
                SHIFT: begin
                    if (w_div_last) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            r_shift <= {r_shift[c_NBITS-2:0], dout};
                        end else if (!w_bit_last) begin
                            r_bit <= r_bit + c_BIT_W'(1);
                        end
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end
                DONE: begin
                    r_pulse <= r_pulse + c_PUL_W'(1);
                end
                default: ;
            endcase

            // Publish the whole frame at once on DONE entry.
            if (w_shift_end) begin
                mat     <= w_frame;
                r_pulse <= '0;
            end
        end
    end

endmodule
`default_nettype wire
